// File: rtl/rr_arbiter_dec_drv.sv
// rtl/rr_arbiter_dec_drv.sv - round-robin arbiter driving a 2x4 active-low decoder (A, B, E)
// Grant windows are separated by a forced one-cycle GAP so no two D lines go low back to back.
module rr_arbiter_dec_drv #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic       a,
  output logic       b,
  output logic       e,
  output logic [1:0] owner,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             timeout_q, timeout_d;

  logic [1:0]       winner;
  logic             found;
  logic             rel_done, rel_req, rel_to;

  // Rotating priority search starting at ptr; 2-bit index arithmetic wraps mod 4.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && req[ptr_q + 2'(i)]) begin
        winner = ptr_q + 2'(i);
        found  = 1'b1;
      end
    end
  end

  assign rel_done = done;
  assign rel_req  = ~req[owner_q];
  assign rel_to   = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          owner_d    = winner;
          hold_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (hold_cnt_q != '1) hold_cnt_d = hold_cnt_q + 1'b1;
        if (rel_done || rel_req || rel_to) begin
          state_d   = GAP;
          ptr_d     = owner_q + 2'd1;
          timeout_d = rel_to && !rel_done && !rel_req;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Outputs decode registers only; IDLE<->GRANT differ in one state bit so e cannot glitch low.
  assign e           = (state_q != GRANT);
  assign grant_valid = (state_q == GRANT);
  assign a           = ~owner_q[1];
  assign b           = ~owner_q[0];
  assign owner       = owner_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_dec_drv.sv
// tb/tb_rr_arbiter_dec_drv.sv - self-checking bench for rr_arbiter_dec_drv
// Behavioural model tracks grant windows as counts of completed cycles; a negedge process compares.
module tb_rr_arbiter_dec_drv;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req = 4'b0;
  logic       done = 1'b0;
  logic       a, b, e, grant_valid, timeout;
  logic [1:0] owner;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  rr_arbiter_dec_drv #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .done(done),
    .a(a), .b(b), .e(e), .owner(owner),
    .grant_valid(grant_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Model: granted/in-gap flags, owner, next search start, completed grant cycles.
  bit m_grant, m_gap, m_to;
  int m_owner, m_ptr, m_held;
  int m_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_grant = 0; m_gap = 0; m_to = 0;
    m_owner = 0; m_ptr = 0; m_held = 0;
  endtask

  task automatic model_step();
    bit rd, rr, rt, hit;
    if (m_grant) begin
      m_held++;
      rd = done;
      rr = !req[m_owner];
      rt = (MAX_HOLD > 0) && (m_held == MAX_HOLD);
      m_to = 0;
      if (rd || rr || rt) begin
        m_grant = 0;
        m_gap   = 1;
        m_ptr   = (m_owner + 1) % 4;
        m_to    = rt && !rd && !rr;
      end
    end else if (m_gap) begin
      m_gap = 0;
      m_to  = 0;
    end else begin
      hit = 0;
      m_to = 0;
      for (int i = 0; i < 4; i++) begin
        if (!hit && req[(m_ptr + i) % 4]) begin
          hit      = 1;
          m_owner  = (m_ptr + i) % 4;
        end
      end
      if (hit) begin
        m_grant = 1;
        m_held  = 0;
        m_log.push_back(m_owner);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    req = 4'b0;
    done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_log.delete();
  endtask

  // Per-cycle comparison plus break-before-make spacing between grant windows.
  bit prev_e = 1'b1;
  bit seen_grant = 1'b0;
  int high_run = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("e", e, !m_grant);
      check("grant_valid", grant_valid, m_grant);
      check("owner", owner, m_owner);
      check("a", a, ((m_owner >> 1) & 1) == 0);
      check("b", b, (m_owner & 1) == 0);
      check("timeout", timeout, m_to);
      if (!reset_n) begin
        seen_grant = 0;
        high_run = 0;
      end else if (e === 1'b0) begin
        if (prev_e && seen_grant) check("gap_len_ge2", high_run >= 2, 1);
        seen_grant = 1;
        high_run = 0;
      end else begin
        high_run++;
      end
      prev_e = e;
    end
  end

  int cnt;
  logic [3:0] dq[$];
  logic main_prev_e;

  initial begin
    model_reset();
    do_reset();
    chk_en = 1'b1;

    // Idle with no requests
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_e", e, 1);
      check("idle_gv", grant_valid, 0);
      check("idle_ab", {a, b}, 2'b11);
    end

    // Requester 2, done in third grant cycle
    req = 4'b0100;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (e === 1'b0) cnt++;
      check("r2_ab", {a, b}, 2'b01);
      if (i == 2) done = 1'b1;
    end
    tick();
    done = 1'b0;
    check("r2_grant_len", cnt, 3);
    check("r2_gap_e", e, 1);
    check("r2_gap_to", timeout, 0);
    check("r2_ptr_model", m_ptr, 3);
    req = 4'b0;
    tick();

    // All requesting, done every 2nd grant cycle
    do_reset();
    req = 4'b1111;
    main_prev_e = 1'b1;
    for (int i = 0; i < 100 && m_log.size() < 5; i++) begin
      tick();
      done = (m_grant && m_held == 1);
      if (e === 1'b0 && main_prev_e === 1'b1) dq.push_back(~(4'b0001 << {~a, ~b}));
      main_prev_e = e;
    end
    check("rr_log_size", m_log.size(), 5);
    if (m_log.size() >= 5) begin
      check("rr_o0", m_log[0], 0);
      check("rr_o1", m_log[1], 1);
      check("rr_o2", m_log[2], 2);
      check("rr_o3", m_log[3], 3);
      check("rr_o4", m_log[4], 0);
    end
    check("rr_dq_size", dq.size(), 5);
    if (dq.size() >= 5) begin
      check("rr_d0", dq[0], 4'b1110);
      check("rr_d1", dq[1], 4'b1101);
      check("rr_d2", dq[2], 4'b1011);
      check("rr_d3", dq[3], 4'b0111);
      check("rr_d4", dq[4], 4'b1110);
    end
    done = 1'b0;

    // Timeout on a persistent requester
    do_reset();
    req = 4'b0010;
    tick();
    check("to_ab", {a, b}, 2'b10);
    cnt = 0;
    for (int i = 0; i < 20 && e === 1'b0; i++) begin
      cnt++;
      tick();
    end
    check("to_len", cnt, 8);
    check("to_pulse", timeout, 1);
    tick();
    check("to_pulse_end", timeout, 0);
    tick();
    check("to_regrant_e", e, 0);
    check("to_regrant_owner", owner, 1);

    // Owner drops its request
    do_reset();
    req = 4'b0010;
    tick();
    tick();
    req = 4'b0000;
    tick();
    check("drop_gap_e", e, 1);
    check("drop_to", timeout, 0);

    // done coincides with the timeout threshold
    do_reset();
    req = 4'b0010;
    tick();
    repeat (7) tick();
    check("thr_still_grant", e, 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("thr_gap_e", e, 1);
    check("thr_to", timeout, 0);

    // Asynchronous reset mid-grant
    do_reset();
    req = 4'b1000;
    tick();
    check("ar_owner3", owner, 3);
    tick();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("ar_e", e, 1);
    check("ar_ab", {a, b}, 2'b11);
    check("ar_owner", owner, 0);
    check("ar_gv", grant_valid, 0);
    #3;
    reset_n = 1'b1;
    tick();
    check("ar_rel_owner", owner, 3);
    check("ar_rel_ab", {a, b}, 2'b00);
    check("ar_rel_e", e, 0);

    // Randomised traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) req = 4'($urandom);
      done = ($urandom_range(7) == 0);
      tick();
    end
    req = 4'b0;
    done = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
